// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: bit-timer/consumer side signals of the UART RX frame assembler
interface uart_rx_frame_if #(
    parameter int DATA_BITS  = 8,
    parameter int FRAME_BITS = 11
);
    logic                  data_in;
    logic                  shift;
    logic                  clear;
    logic                  data_ready;
    logic [FRAME_BITS-1:0] frame_out;
    logic [DATA_BITS-1:0]  data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;
    logic                  busy;
    modport master (
        output data_in, shift, clear, data_ready,
        input  frame_out, data_out, data_valid, parity_err, frame_err, overrun, busy
    );
    modport slave (
        input  data_in, shift, clear, data_ready,
        output frame_out, data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_frame_shiftreg.sv
// uart_rx_frame_shiftreg: UART RX frame assembler with start detect, parity/stop check and valid/ready holding register
module uart_rx_frame_shiftreg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic            clk,
    input logic            reset,
    uart_rx_frame_if.slave bus
);
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int CW = $clog2(FRAME_BITS + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [FRAME_BITS-1:0] frame;
    logic [DATA_BITS-1:0]  data;
    logic                  valid, par_err, frm_err, ovr;
    logic                  take, load, last, par_bad;
    // outside a frame a 1 is line idle, so only a 0 is captured there
    assign take    = bus.shift & ~bus.clear & ((state == SHIFT) | ~bus.data_in);
    assign load    = state == LOAD;
    assign last    = cnt == CW'(FRAME_BITS - 1);
    assign par_bad = (^frame[DATA_BITS+1:1]) != 1'(PARITY_ODD);
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.clear) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == SHIFT) begin
            if (take) begin
                state_nx = last ? LOAD : SHIFT;
                cnt_nx   = last ? '0 : cnt + CW'(1);
            end
        end else begin
            state_nx = take ? SHIFT : IDLE;
            cnt_nx   = take ? CW'(1) : '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            frame   <= '1;
            data    <= '0;
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (bus.clear)
                frame <= '1;
            else if (take)
                frame <= {bus.data_in, frame[FRAME_BITS-1:1]};
            // a full holding register only takes the new word if it is drained on the same edge
            if (load & (~valid | bus.data_ready)) begin
                data    <= frame[DATA_BITS:1];
                par_err <= (PARITY_EN != 0) & par_bad;
                frm_err <= ~&frame[FRAME_BITS-1 -: STOP_BITS];
                valid   <= 1'b1;
            end else if (valid & bus.data_ready) begin
                valid <= 1'b0;
            end
            ovr <= ~bus.clear & (ovr | (load & valid & ~bus.data_ready));
        end
    end
    assign bus.frame_out  = frame;
    assign bus.data_out   = data;
    assign bus.data_valid = valid;
    assign bus.parity_err = par_err;
    assign bus.frame_err  = frm_err;
    assign bus.overrun    = ovr;
    assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_uart_rx_frame_shiftreg.sv
// tb_uart_rx_frame_shiftreg: table vectors, directed corner sequences and random traffic against a frame-level model
module tb_uart_rx_frame_shiftreg;
    localparam int DB = 8;
    localparam int FB = 11;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_rx_frame_if #(.DATA_BITS(8), .FRAME_BITS(11)) a ();
    uart_rx_frame_if #(.DATA_BITS(7), .FRAME_BITS(10)) b ();
    uart_rx_frame_shiftreg dut_a (.clk(clk), .reset(rst), .bus(a));
    uart_rx_frame_shiftreg #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut_b (.clk(clk), .reset(rst), .bus(b));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  d;
        logic        p;
        logic        s;
        logic [10:0] frm;
        logic        pe;
        logic        fe;
    } vec_t;
    vec_t vecs[7];

    logic       hist[$];
    logic       rx_bits[$];
    logic [7:0] m_data, p_data;
    logic       m_valid, m_pe, m_fe, m_ovr, m_load, p_pe, p_fe;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(bit sel, logic [15:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            if (sel) begin b.shift = 1'b1; b.data_in = bits[i]; end
            else begin a.shift = 1'b1; a.data_in = bits[i]; end
            tick();
            a.shift = 1'b0; b.shift = 1'b0; a.data_in = 1'b1; b.data_in = 1'b1;
            if (i != n - 1) repeat (3) tick();
        end
    endtask

    task automatic pulse_ready_a();
        a.data_ready = 1'b1;
        tick();
        a.data_ready = 1'b0;
    endtask

    function automatic logic [10:0] model_frame();
        logic [10:0] f;
        f = '1;
        for (int i = 0; i < hist.size(); i++) f[FB - hist.size() + i] = hist[i];
        return f;
    endfunction

    task automatic model_reset();
        hist.delete();
        rx_bits.delete();
        m_data = '0; m_valid = 0; m_pe = 0; m_fe = 0; m_ovr = 0; m_load = 0;
    endtask

    task automatic rand_cycle();
        bit sh, din, rdy, clr;
        int ones;
        sh  = ($urandom_range(0, 2) == 0);
        din = 1'($urandom_range(0, 1));
        rdy = ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 150) == 0);
        a.shift = sh; a.data_in = din; a.data_ready = rdy; a.clear = clr;
        if (m_load && (!m_valid || rdy)) begin
            m_data = p_data; m_pe = p_pe; m_fe = p_fe; m_valid = 1;
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (m_load) m_ovr = 1;
        end
        if (clr) m_ovr = 0;
        m_load = 0;
        if (clr) begin
            hist.delete();
            rx_bits.delete();
        end else if (sh && (rx_bits.size() != 0 || !din)) begin
            hist.push_back(din);
            if (hist.size() > FB) void'(hist.pop_front());
            rx_bits.push_back(din);
            if (rx_bits.size() == FB) begin
                ones = 0;
                for (int i = 0; i < DB; i++) begin
                    p_data[i] = rx_bits[1 + i];
                    ones += int'(rx_bits[1 + i]);
                end
                ones += int'(rx_bits[DB + 1]);
                p_pe = (ones % 2) != 0;
                p_fe = !rx_bits[FB - 1];
                rx_bits.delete();
                m_load = 1;
            end
        end
        tick();
        chk("rnd_frame_out", a.frame_out, model_frame());
        chk("rnd_valid", a.data_valid, m_valid);
        chk("rnd_data_out", a.data_out, m_data);
        chk("rnd_parity_err", a.parity_err, m_pe);
        chk("rnd_frame_err", a.frame_err, m_fe);
        chk("rnd_overrun", a.overrun, m_ovr);
        chk("rnd_busy", a.busy, (rx_bits.size() != 0) || m_load);
    endtask

    initial begin
        a.data_in = 1; a.shift = 0; a.clear = 0; a.data_ready = 0;
        b.data_in = 1; b.shift = 0; b.clear = 0; b.data_ready = 0;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 11'h54A, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 11'h74A, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 11'h14A, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 11'h400, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 11'h5FE, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 11'h602, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 11'h500, 1'b1, 1'b0};
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_frame_out", a.frame_out, 11'h7FF);
        chk("rst_valid", a.data_valid, 0);
        chk("rst_data_out", a.data_out, 0);
        chk("rst_flags", {a.parity_err, a.frame_err, a.overrun, a.busy}, 0);
        chk("rst_frame_out_b", b.frame_out, 10'h3FF);

        foreach (vecs[k]) begin
            send(0, {5'b0, vecs[k].s, vecs[k].p, vecs[k].d, 1'b0}, FB);
            chk("vec_frame_out", a.frame_out, vecs[k].frm);
            chk("vec_valid_early", a.data_valid, 0);
            chk("vec_busy_load", a.busy, 1);
            tick();
            chk("vec_valid", a.data_valid, 1);
            chk("vec_data_out", a.data_out, vecs[k].d);
            chk("vec_parity_err", a.parity_err, vecs[k].pe);
            chk("vec_frame_err", a.frame_err, vecs[k].fe);
            chk("vec_busy_after", a.busy, 0);
            pulse_ready_a();
            chk("vec_consumed", a.data_valid, 0);
        end

        send(0, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, FB);
        tick();
        send(0, {5'b0, 1'b1, 1'b0, 8'h81, 1'b0}, FB);
        tick();
        chk("ovr_data_held", a.data_out, 8'h3C);
        chk("ovr_set", a.overrun, 1);
        chk("ovr_valid", a.data_valid, 1);
        pulse_ready_a();
        chk("ovr_drained", a.data_valid, 0);
        chk("ovr_sticky", a.overrun, 1);
        a.clear = 1'b1;
        tick();
        a.clear = 1'b0;
        chk("ovr_cleared", a.overrun, 0);

        send(0, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, FB);
        tick();
        send(0, {5'b0, 1'b1, 1'b0, 8'h81, 1'b0}, FB);
        a.data_ready = 1'b1;
        tick();
        a.data_ready = 1'b0;
        chk("swap_data", a.data_out, 8'h81);
        chk("swap_valid", a.data_valid, 1);
        chk("swap_no_ovr", a.overrun, 0);
        pulse_ready_a();

        a.clear = 1'b1; a.shift = 1'b1; a.data_in = 1'b0;
        tick();
        a.clear = 1'b0; a.shift = 1'b0; a.data_in = 1'b1;
        chk("clr_shift_busy", a.busy, 0);
        chk("clr_shift_frame", a.frame_out, 11'h7FF);

        send(0, 16'h001F, 5);
        chk("idle_ones_frame", a.frame_out, 11'h7FF);
        chk("idle_ones_busy", a.busy, 0);
        send(0, 16'b1010, 4);
        chk("partial_busy", a.busy, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_frame", a.frame_out, 11'h7FF);
        chk("async_rst_busy", a.busy, 0);
        chk("async_rst_out", {a.data_out, a.data_valid, a.parity_err, a.frame_err, a.overrun}, 0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("after_rst_no_valid", a.data_valid, 0);

        send(1, {6'b0, 2'b11, 7'h55, 1'b0}, 10);
        chk("b_frame_out", b.frame_out, 10'h3AA);
        tick();
        chk("b_valid", b.data_valid, 1);
        chk("b_data_out", b.data_out, 7'h55);
        chk("b_parity_err", b.parity_err, 0);
        chk("b_frame_err", b.frame_err, 0);
        b.data_ready = 1'b1;
        tick();
        b.data_ready = 1'b0;
        send(1, {6'b0, 2'b01, 7'h55, 1'b0}, 10);
        chk("b_frame_out_bad", b.frame_out, 10'h1AA);
        tick();
        chk("b_stop2_err", b.frame_err, 1);
        chk("b_stop2_parity", b.parity_err, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) rand_cycle();
        a.shift = 0; a.clear = 0; a.data_ready = 0; a.data_in = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
